// File: rtl/alu_issue_queue.sv
// Issue stage in front of a fixed-latency 32-bit ALU: input FIFO, registered ALU drive,
// tag/err tracking pipe and a credit-protected result FIFO with valid/ready output.
module alu_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [3:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);
    localparam int RDEPTH = ALU_LAT + 1;
    localparam int QPW    = $clog2(DEPTH);
    localparam int QCW    = $clog2(DEPTH + 1);
    localparam int RPW    = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
    localparam int RCW    = $clog2(RDEPTH + 1);
    localparam int SW     = RCW + 1;
    localparam logic [3:0] OP_BUBBLE = 4'b1111;

    function automatic logic is_illegal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0010, 4'b1010, 4'b0100,
            4'b0101, 4'b0110, 4'b0111: return 1'b0;
            default:                   return 1'b1;
        endcase
    endfunction

    logic [31:0]      q_a     [DEPTH];
    logic [31:0]      q_b     [DEPTH];
    logic [3:0]       q_op    [DEPTH];
    logic [TAG_W-1:0] q_tag   [DEPTH];
    logic             q_err   [DEPTH];
    logic [QPW-1:0]   q_wr_reg, q_rd_reg;
    logic [QCW-1:0]   q_count_reg;

    logic             pipe_valid_reg [ALU_LAT];
    logic [TAG_W-1:0] pipe_tag_reg   [ALU_LAT];
    logic             pipe_err_reg   [ALU_LAT];
    logic             pipe_valid_next [ALU_LAT];
    logic [TAG_W-1:0] pipe_tag_next   [ALU_LAT];
    logic             pipe_err_next   [ALU_LAT];

    logic [31:0]      r_result_reg [RDEPTH];
    logic             r_zero_reg   [RDEPTH];
    logic [TAG_W-1:0] r_tag_reg    [RDEPTH];
    logic             r_err_reg    [RDEPTH];
    logic [RPW-1:0]   r_wr_reg, r_rd_reg;
    logic [RCW-1:0]   r_count_reg;

    logic [31:0]      a_reg, b_reg;
    logic [3:0]       op_reg;

    logic             push, issue, capture, out_pop;
    logic [RCW-1:0]   inflight;
    logic [SW-1:0]    credits_used;

    assign in_ready  = reset & (q_count_reg < QCW'(DEPTH));
    assign push      = in_valid & in_ready;
    assign out_valid = (r_count_reg != '0);
    assign out_pop   = out_valid & out_ready;
    assign capture   = pipe_valid_reg[ALU_LAT-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ALU_LAT; i++) begin
            inflight = inflight + RCW'(pipe_valid_reg[i]);
        end
    end

    // A result popped this cycle frees its slot for this cycle's issue; without
    // this the loop cannot sustain one issue per cycle with RDEPTH = ALU_LAT+1.
    assign credits_used = SW'(inflight) + SW'(r_count_reg) - SW'(out_pop);
    assign issue        = (q_count_reg != '0) && (credits_used < SW'(RDEPTH));

    always_ff @(posedge clk) begin
        if (push) begin
            q_a[q_wr_reg]   <= in_a;
            q_b[q_wr_reg]   <= in_b;
            q_op[q_wr_reg]  <= in_op;
            q_tag[q_wr_reg] <= in_tag;
            q_err[q_wr_reg] <= is_illegal(in_op);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_wr_reg    <= '0;
            q_rd_reg    <= '0;
            q_count_reg <= '0;
        end else begin
            if (push)  q_wr_reg <= q_wr_reg + 1'b1;
            if (issue) q_rd_reg <= q_rd_reg + 1'b1;
            case ({push, issue})
                2'b10:   q_count_reg <= q_count_reg + 1'b1;
                2'b01:   q_count_reg <= q_count_reg - 1'b1;
                default: q_count_reg <= q_count_reg;
            endcase
        end
    end

    // Operands hold across bubbles; only the opcode is forced to the bubble code.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= OP_BUBBLE;
        end else if (issue) begin
            a_reg  <= q_a[q_rd_reg];
            b_reg  <= q_b[q_rd_reg];
            op_reg <= q_op[q_rd_reg];
        end else begin
            op_reg <= OP_BUBBLE;
        end
    end

    assign alu_a  = a_reg;
    assign alu_b  = b_reg;
    assign alu_op = op_reg;

    assign pipe_valid_next[0] = issue;
    assign pipe_tag_next[0]   = q_tag[q_rd_reg];
    assign pipe_err_next[0]   = q_err[q_rd_reg];

    generate
        for (genvar gi = 1; gi < ALU_LAT; gi++) begin : g_pipe
            assign pipe_valid_next[gi] = pipe_valid_reg[gi-1];
            assign pipe_tag_next[gi]   = pipe_tag_reg[gi-1];
            assign pipe_err_next[gi]   = pipe_err_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ALU_LAT; i++) begin
                pipe_valid_reg[i] <= 1'b0;
                pipe_tag_reg[i]   <= '0;
                pipe_err_reg[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < ALU_LAT; i++) begin
                pipe_valid_reg[i] <= pipe_valid_next[i];
                pipe_tag_reg[i]   <= pipe_tag_next[i];
                pipe_err_reg[i]   <= pipe_err_next[i];
            end
        end
    end

    // Storage is cleared on reset so the head reads as zero while empty after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RDEPTH; i++) begin
                r_result_reg[i] <= '0;
                r_zero_reg[i]   <= 1'b0;
                r_tag_reg[i]    <= '0;
                r_err_reg[i]    <= 1'b0;
            end
            r_wr_reg    <= '0;
            r_rd_reg    <= '0;
            r_count_reg <= '0;
        end else begin
            if (capture) begin
                r_result_reg[r_wr_reg] <= alu_result;
                r_zero_reg[r_wr_reg]   <= alu_zero;
                r_tag_reg[r_wr_reg]    <= pipe_tag_reg[ALU_LAT-1];
                r_err_reg[r_wr_reg]    <= pipe_err_reg[ALU_LAT-1];
                r_wr_reg <= (r_wr_reg == RPW'(RDEPTH-1)) ? '0 : r_wr_reg + 1'b1;
            end
            if (out_pop) begin
                r_rd_reg <= (r_rd_reg == RPW'(RDEPTH-1)) ? '0 : r_rd_reg + 1'b1;
            end
            case ({capture, out_pop})
                2'b10:   r_count_reg <= r_count_reg + 1'b1;
                2'b01:   r_count_reg <= r_count_reg - 1'b1;
                default: r_count_reg <= r_count_reg;
            endcase
        end
    end

    assign out_result = r_result_reg[r_rd_reg];
    assign out_zero   = r_zero_reg[r_rd_reg];
    assign out_tag    = r_tag_reg[r_rd_reg];
    assign out_err    = r_err_reg[r_rd_reg];

endmodule
